// File: rtl/time_keeper_pkg.sv
// Shared constants for the 12-hour time-of-day counter: mode code, field limits
// and FSM encodings used by time_keeper and its prescaler.
package time_keeper_pkg;

    localparam logic [3:0] MODE_TIME_SET = 4'b0000;

    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] HOUR_MAX = 7'd11;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

endpackage

// File: rtl/time_keeper_tick.sv
// Clock prescaler: one-cycle TICK every TICK_DIV cycles, restarted by CLR.
module tick_gen #(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    output logic TICK
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;

    // TICK is combinational so the owner can advance on the same edge the count wraps.
    assign tick = (cnt_q == CNT_LAST) && !CLR;
    assign TICK = tick;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (CLR || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 12-hour time-of-day counter: freezes during time-set, loads the set values on
// exit, then advances once per prescaler tick with SEC_TICK / DAY_CARRY pulses.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] MODE,
    input  logic       SET_MERIDIEM,
    input  logic [6:0] SET_HOUR,
    input  logic [6:0] SET_MIN,
    input  logic [6:0] SET_SEC,
    output logic       MERIDIEM,
    output logic [6:0] HOUR,
    output logic [6:0] MIN,
    output logic [6:0] SEC,
    output logic       SEC_TICK,
    output logic       DAY_CARRY
);

    // The set stage can hand over wrapped values, so anything out of range loads as 0.
    function automatic logic [6:0] sanitize(input logic [6:0] val, input logic [6:0] max_val);
        return (val > max_val) ? 7'd0 : val;
    endfunction

    logic [1:0] state_q,     state_d;
    logic       meridiem_q,  meridiem_d;
    logic [6:0] hour_q,      hour_d;
    logic [6:0] min_q,       min_d;
    logic [6:0] sec_q,       sec_d;
    logic       sec_tick_q,  sec_tick_d;
    logic       day_carry_q, day_carry_d;

    logic mode_set;
    logic presc_clr;
    logic tick;

    assign mode_set  = (MODE == MODE_TIME_SET);
    // Clearing on mode_set as well makes hold win over a coincident tick.
    assign presc_clr = (state_q != S_RUN) || mode_set;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (presc_clr),
        .TICK  (tick)
    );

    always_comb begin
        state_d     = state_q;
        meridiem_d  = meridiem_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        sec_tick_d  = 1'b0;
        day_carry_d = 1'b0;

        case (state_q)
            S_RUN: begin
                if (mode_set) begin
                    state_d = S_HOLD;
                end else if (tick) begin
                    sec_tick_d = 1'b1;
                    if (sec_q == SEC_MAX) begin
                        sec_d = 7'd0;
                        if (min_q == MIN_MAX) begin
                            min_d = 7'd0;
                            if (hour_q == HOUR_MAX) begin
                                hour_d      = 7'd0;
                                meridiem_d  = ~meridiem_q;
                                day_carry_d = meridiem_q;
                            end else begin
                                hour_d = hour_q + 7'd1;
                            end
                        end else begin
                            min_d = min_q + 7'd1;
                        end
                    end else begin
                        sec_d = sec_q + 7'd1;
                    end
                end
            end
            S_HOLD: begin
                if (!mode_set) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                meridiem_d = SET_MERIDIEM;
                hour_d     = sanitize(SET_HOUR, HOUR_MAX);
                min_d      = sanitize(SET_MIN, MIN_MAX);
                sec_d      = sanitize(SET_SEC, SEC_MAX);
                state_d    = mode_set ? S_HOLD : S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_RUN;
            meridiem_q  <= 1'b0;
            hour_q      <= 7'd0;
            min_q       <= 7'd0;
            sec_q       <= 7'd0;
            sec_tick_q  <= 1'b0;
            day_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            meridiem_q  <= meridiem_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sec_tick_q  <= sec_tick_d;
            day_carry_q <= day_carry_d;
        end
    end

    assign MERIDIEM  = meridiem_q;
    assign HOUR      = hour_q;
    assign MIN       = min_q;
    assign SEC       = sec_q;
    assign SEC_TICK  = sec_tick_q;
    assign DAY_CARRY = day_carry_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV=4; expected values hand-computed.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] mode;
    logic       set_mer;
    logic [6:0] set_hour;
    logic [6:0] set_min;
    logic [6:0] set_sec;
    logic       mer;
    logic [6:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
    logic       sec_tick;
    logic       day_carry;

    int n_cmp = 0;
    int n_err = 0;
    int ticks;

    time_keeper #(
        .TICK_DIV (4),
        .CNT_W    (2)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .MODE         (mode),
        .SET_MERIDIEM (set_mer),
        .SET_HOUR     (set_hour),
        .SET_MIN      (set_min),
        .SET_SEC      (set_sec),
        .MERIDIEM     (mer),
        .HOUR         (hour),
        .MIN          (min),
        .SEC          (sec),
        .SEC_TICK     (sec_tick),
        .DAY_CARRY    (day_carry)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string tag, input int m, input int h, input int mi, input int s);
        check_eq({tag, ".mer"},  32'(mer),  32'(m));
        check_eq({tag, ".hour"}, 32'(hour), 32'(h));
        check_eq({tag, ".min"},  32'(min),  32'(mi));
        check_eq({tag, ".sec"},  32'(sec),  32'(s));
    endtask

    task automatic set_vals(input logic m, input logic [6:0] h, input logic [6:0] mi, input logic [6:0] s);
        set_mer  = m;
        set_hour = h;
        set_min  = mi;
        set_sec  = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        mode = 4'd1;
        set_vals(1'b0, 7'd0, 7'd0, 7'd0);
        step(2);
        check_time("reset", 0, 0, 0, 0);
        check_eq("reset.tick",  32'(sec_tick),  0);
        check_eq("reset.carry", 32'(day_carry), 0);
        rst = 1'b0;

        // Free run for 12 cycles: ticks on cycles 4, 8, 12.
        for (int i = 1; i <= 12; i++) begin
            step(1);
            check_eq($sformatf("run.tick%0d", i), 32'(sec_tick), (i % 4 == 0) ? 1 : 0);
        end
        check_time("run12", 0, 0, 0, 3);

        // Load PM 11:59:59 and roll over to AM 0:00:00.
        mode = 4'd0;
        set_vals(1'b1, 7'd11, 7'd59, 7'd59);
        step(1);
        check_time("hold_enter", 0, 0, 0, 3);
        mode = 4'd1;
        step(2);
        check_time("load_pm", 1, 11, 59, 59);
        step(3);
        check_eq("pre_roll.sec",  32'(sec), 59);
        check_eq("pre_roll.tick", 32'(sec_tick), 0);
        step(1);
        check_time("roll", 0, 0, 0, 0);
        check_eq("roll.carry", 32'(day_carry), 1);
        check_eq("roll.tick",  32'(sec_tick), 1);
        step(1);
        check_eq("roll_next.carry", 32'(day_carry), 0);
        check_eq("roll_next.tick",  32'(sec_tick), 0);

        // Count to SEC=5, then hold 20 cycles.
        step(19);
        check_eq("sec5", 32'(sec), 5);
        mode = 4'd0;
        set_vals(1'b0, 7'd3, 7'd14, 7'd15);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (sec !== 7'd5) ticks += 100;
            if (sec_tick) ticks++;
        end
        check_eq("hold20.frozen_and_quiet", 32'(ticks), 0);
        mode = 4'd2;
        step(1);
        check_eq("hold_exit.still5", 32'(sec), 5);
        step(1);
        check_time("load_3_14_15", 0, 3, 14, 15);

        // Out-of-range set values sanitize to zero.
        mode = 4'd0;
        set_vals(1'b1, 7'd13, 7'd122, 7'd60);
        step(1);
        mode = 4'd1;
        step(2);
        check_time("sanitize", 1, 0, 0, 0);

        // Hold wins over a coincident tick at SEC=7.
        step(28);
        check_eq("sec7", 32'(sec), 7);
        step(3);
        mode = 4'd0;
        step(1);
        check_eq("coinc.sec",  32'(sec), 7);
        check_eq("coinc.tick", 32'(sec_tick), 0);
        step(3);
        check_eq("coinc_hold.sec", 32'(sec), 7);

        // One-cycle MODE glitch: load happens, then back to hold.
        set_vals(1'b0, 7'd9, 7'd8, 7'd7);
        mode = 4'd1;
        step(1);
        mode = 4'd0;
        step(1);
        check_time("glitch_load", 0, 9, 8, 7);
        step(8);
        check_time("glitch_hold", 0, 9, 8, 7);

        // Load PM 5:30:20 and reset asynchronously mid-count.
        set_vals(1'b1, 7'd5, 7'd30, 7'd20);
        mode = 4'd1;
        step(2);
        check_time("load_pm5", 1, 5, 30, 20);
        step(2);
        #2 rst = 1'b1;
        #1;
        check_time("async_rst", 0, 0, 0, 0);
        step(1);
        rst = 1'b0;
        step(3);
        check_eq("post_rst3.sec",  32'(sec), 0);
        check_eq("post_rst3.tick", 32'(sec_tick), 0);
        step(1);
        check_eq("post_rst4.sec",  32'(sec), 1);
        check_eq("post_rst4.tick", 32'(sec_tick), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
